accum_arbiter: RTL and testbench
================================

// Module: accum_arbiter
// PURPOSE
//  Round-robin controller sharing one Accumulator between NREQ requesters.
//  Grants one requester at a time and streams its 1-3 byte burst onto putFlag/value.
//  Waits for the Accumulator's done, then returns a one-hot completion (or timeout) pulse.
//  Sits between the operand-producing units and the Accumulator; the requester reads r0..r2 directly.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  TIMEOUT  16  max cycles in WAIT for acc_done before error completion (>=2)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        synchronous, active-low reset
//  req        in   NREQ     per-requester request level, held until rsp_valid bit
//  req_len    in   2*NREQ   packed burst length per requester, [2i+1:2i], legal 1..3
//  req_data   in   8*NREQ   packed current byte per requester, [8i+7:8i]
//  gnt        out  NREQ     one-hot grant, high from PUSH through RESP
//  data_ack   out  NREQ     byte consumed this cycle (= gnt & acc_put); requester advances
//  acc_put    out  1        to Accumulator putFlag
//  acc_value  out  8        to Accumulator value (req_data of granted requester, else 0)
//  acc_done   in   1        from Accumulator done
//  rsp_valid  out  NREQ     one-cycle one-hot completion pulse to the granted requester
//  rsp_err    out  1        qualifies rsp_valid: 1 = timed out, results invalid
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state IDLE, rr pointer 0, gnt/data_ack/acc_put/rsp_valid/
//    rsp_err/busy all 0, acc_value 0, len/beat/timeout counters 0. Overrides every state,
//    including mid-burst; acc_put drops the cycle after the reset edge, no rsp issued.
//  - FSM: IDLE -> PUSH -> GAP -> WAIT -> RESP -> IDLE.
//  - IDLE: if |req, pick first set bit searching from rr pointer upward with wrap;
//    latch winner index and its req_len (0 latched as 1); rr pointer <= winner+1 mod NREQ;
//    go PUSH. No req: stay, outputs 0.
//  - PUSH: gnt and acc_put high; one beat per cycle; beat counter 1..len; after len beats go GAP.
//    Latency: req seen at edge t -> gnt/acc_put/first data_ack high in cycle t+1.
//  - GAP: one cycle acc_put=0 (burst terminator for the Accumulator); go WAIT; clear timeout ctr.
//  - WAIT: acc_done==1 -> RESP, rsp_err<=0. Else ctr++; ctr reaching TIMEOUT -> RESP, rsp_err<=1.
//    acc_done arriving in GAP is ignored; only WAIT samples it.
//  - RESP: rsp_valid = gnt for exactly one cycle with rsp_err; next edge -> IDLE, gnt cleared.
//    Minimum idle-to-idle: len+4 cycles; back-to-back grants need one IDLE cycle between.
//  - req dropped mid-transaction: ignored; transaction runs to RESP. req_len/req_data of
//    non-granted requesters ignored; req_len changes after grant ignored.
//  - acc_value = req_data[winner] combinationally while acc_put, else 0.
//  - gnt, rsp_valid, data_ack always one-hot or zero; never two bits set.
// TESTING
//  1 Single req[0], len=1, data 8'h0A, acc_done 2 cyc into WAIT -> gnt=0001 one cycle after req,
//    one put of 0x0A, GAP, rsp_valid=0001 rsp_err=0, back in IDLE at cycle 6.
//  2 req=1111 simultaneous, len=1 each, rr=0 -> grants in order 0,1,2,3; then req[1],req[0]
//    again -> 1 granted first wait... no: pointer=0 after 3, so 0 then 1.
//  3 req[2] len=3, bytes 0x28,0x32,0x3C -> acc_put high 3 consecutive cycles, data_ack[2] each,
//    acc_value sequence 0x28,0x32,0x3C, then acc_put 0 for GAP.
//  4 acc_done never asserted, TIMEOUT=16 -> exactly 16 WAIT cycles, rsp_valid with rsp_err=1.
//  5 reset low during 2nd beat of len=3 burst -> next cycle all outputs 0, IDLE, no rsp_valid;
//    next req granted from rr pointer 0.
//  6 req_len=0 on req[1]; req[3] dropped mid-PUSH -> len 0 treated as 1 beat; dropped
//    req[3] transaction still completes with rsp_valid[3].

Source files
------------

// File: rtl/accum_arbiter.sv
// Round-robin arbiter that lends a single Accumulator to NREQ requesters, streams the
// granted requester's 1-3 byte burst, waits for done (or timeout) and returns a one-hot completion.
module accum_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_len,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     data_ack,
  output logic                acc_put,
  output logic [7:0]          acc_value,
  input  logic                acc_done,
  output logic [NREQ-1:0]     rsp_valid,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    GAP  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   rr_r;
  logic [IW-1:0]   winner_r;
  logic [1:0]      len_r;
  logic [1:0]      beat_r;
  logic [TW-1:0]   tmo_r;
  logic            err_r;
  logic [IW-1:0]   cand_s;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_found_s;
  logic [1:0]      pick_len_s;
  logic [NREQ-1:0] winner_oh_s;
  logic [1:0]      len_arr_s  [NREQ];
  logic [7:0]      data_arr_s [NREQ];

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      wrap_idx = IW'(sum - NREQ);
    end else begin
      wrap_idx = IW'(sum);
    end
  endfunction

  // Unpack per-requester lengths and bytes.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      len_arr_s[k]  = req_len[2*k +: 2];
      data_arr_s[k] = req_data[8*k +: 8];
    end
  end

  // Round-robin pick: descending scan so the smallest offset from rr_r wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s       = wrap_idx(rr_r, k);
      pick_found_s = pick_found_s | req[cand_s];
      pick_idx_s   = req[cand_s] ? cand_s : pick_idx_s;
    end
    pick_len_s = (len_arr_s[pick_idx_s] == 2'd0) ? 2'd1 : len_arr_s[pick_idx_s];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = pick_found_s ? PUSH : IDLE;
      PUSH:    state_nxt_s = (beat_r == len_r) ? GAP : PUSH;
      GAP:     state_nxt_s = WAIT;
      WAIT:    state_nxt_s = (acc_done || (tmo_r == TMO_LAST)) ? RESP : WAIT;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Transaction context: winner, burst length, beat and timeout counters, error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_r     <= '0;
      winner_r <= '0;
      len_r    <= 2'd0;
      beat_r   <= 2'd0;
      tmo_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            winner_r <= pick_idx_s;
            len_r    <= pick_len_s;
            beat_r   <= 2'd1;
            rr_r     <= (pick_idx_s == IDX_LAST) ? '0 : pick_idx_s + IW'(1);
          end else begin
            beat_r   <= 2'd0;
          end
        end
        PUSH: begin
          if (beat_r != len_r) begin
            beat_r <= beat_r + 2'd1;
          end else begin
            beat_r <= beat_r;
          end
        end
        GAP: tmo_r <= '0;
        WAIT: begin
          if (acc_done) begin
            err_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TW'(1);
            err_r <= (tmo_r == TMO_LAST);
          end
        end
        default: begin
          tmo_r <= tmo_r;
        end
      endcase
    end
  end

  assign winner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_r;

  // Outputs decoded from state and the latched winner.
  always_comb begin
    gnt       = '0;
    acc_put   = 1'b0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    busy      = (state_r != IDLE);
    case (state_r)
      PUSH: begin
        gnt     = winner_oh_s;
        acc_put = 1'b1;
      end
      GAP, WAIT: gnt = winner_oh_s;
      RESP: begin
        gnt       = winner_oh_s;
        rsp_valid = winner_oh_s;
        rsp_err   = err_r;
      end
      default: gnt = '0;
    endcase
  end

  assign data_ack  = gnt & {NREQ{acc_put}};
  assign acc_value = acc_put ? data_arr_s[winner_r] : 8'h00;

endmodule

// File: tb/tb_accum_arbiter.sv
// Scoreboard bench for accum_arbiter: directed bursts queue expected beats/completions,
// a negedge monitor pops and compares whenever the DUT acks a byte or completes.
module tb_accum_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_len;
  logic [8*NREQ-1:0] req_data;
  logic              acc_done;
  logic [NREQ-1:0]   gnt, data_ack, rsp_valid;
  logic              acc_put, rsp_err, busy;
  logic [7:0]        acc_value;

  accum_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
    .gnt(gnt), .data_ack(data_ack), .acc_put(acc_put), .acc_value(acc_value),
    .acc_done(acc_done), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [7:0] val; } beat_t;
  typedef struct { int idx; logic err; } rsp_t;
  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  int total = 0;
  int bad   = 0;
  logic [7:0] mem [NREQ][3];
  int ptr [NREQ];
  int done_delay = 0;
  int wcnt = 0;
  logic armed = 1'b0;
  logic prev_put = 1'b0;
  int n;
  logic seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = mem[i][(ptr[i] < 3) ? ptr[i] : 2];
  endtask

  task automatic load(input int i, input logic [1:0] len, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2);
    mem[i][0] = b0; mem[i][1] = b1; mem[i][2] = b2;
    ptr[i] = 0;
    req_len[2*i +: 2] = len;
    refresh();
  endtask

  task automatic exp_beat(input int i, input logic [7:0] v);
    beat_t b; b.idx = i; b.val = v; beat_q.push_back(b);
  endtask

  task automatic exp_rsp(input int i, input logic e);
    rsp_t r; r.idx = i; r.err = e; rsp_q.push_back(r);
  endtask

  // One clock: requester/accumulator models observe at negedge, act just after posedge.
  task automatic step();
    logic [NREQ-1:0] ack, rv;
    @(negedge clk);
    ack = data_ack;
    rv  = rsp_valid;
    if (rv != '0) armed = 1'b0;
    else if (prev_put && !acc_put && gnt != '0) begin armed = 1'b1; wcnt = 0; end
    else if (armed) wcnt++;
    acc_done = armed && (done_delay != 0) && (wcnt == done_delay);
    prev_put = acc_put;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) ptr[i]++;
      if (rv[i]) req[i] = 1'b0;
    end
    refresh();
  endtask

  task automatic drain(input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while ((busy || req != '0) && cnt < budget);
    chk("drain_budget", 32'(busy | (|req)), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; acc_done = 1'b0; armed = 1'b0; prev_put = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (gnt != '0) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    if (data_ack != '0) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 32'(data_ack), 32'd0);
      else begin
        b = beat_q.pop_front();
        chk("beat_ack", 32'(data_ack), 32'(1 << b.idx));
        chk("beat_value", 32'(acc_value), 32'(b.val));
      end
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << r.idx));
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_len = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) load(i, 2'd1, 8'h00, 8'h00, 8'h00);
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_put", 32'(acc_put), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    chk("rst_value", 32'(acc_value), 32'd0);

    // 1: single req[0], len 1, done two cycles into WAIT
    load(0, 2'd1, 8'h0A, 8'h00, 8'h00);
    exp_beat(0, 8'h0A); exp_rsp(0, 1'b0);
    done_delay = 2;
    req = 4'b0001;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_put", 32'(acc_put), 32'd1);
    drain(40, n);
    chk("t1_idle_cycle", 32'(n + 1), 32'd6);

    // 2: all four at once from rr=0, then req[1],req[0] with rr back at 0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      load(i, 2'd1, 8'h10 + 8'(i), 8'h00, 8'h00);
      exp_beat(i, 8'h10 + 8'(i)); exp_rsp(i, 1'b0);
    end
    done_delay = 1;
    req = 4'b1111;
    drain(100, n);
    chk("t2_cycles", 32'(n), 32'd20);
    load(0, 2'd1, 8'hA0, 8'h00, 8'h00);
    load(1, 2'd1, 8'hA1, 8'h00, 8'h00);
    exp_beat(0, 8'hA0); exp_rsp(0, 1'b0);
    exp_beat(1, 8'hA1); exp_rsp(1, 1'b0);
    req = 4'b0011;
    drain(60, n);
    chk("t2b_cycles", 32'(n), 32'd10);

    // 3: three-byte burst on req[2]
    load(2, 2'd3, 8'h28, 8'h32, 8'h3C);
    exp_beat(2, 8'h28); exp_beat(2, 8'h32); exp_beat(2, 8'h3C); exp_rsp(2, 1'b0);
    done_delay = 3;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) step();
    chk("t3_gap_put", 32'(acc_put), 32'd0);
    chk("t3_gap_gnt", 32'(gnt), 32'h4);
    drain(40, n);

    // 4: no done -> timeout after exactly TIMEOUT WAIT cycles
    load(1, 2'd2, 8'h5A, 8'hA5, 8'h00);
    exp_beat(1, 8'h5A); exp_beat(1, 8'hA5); exp_rsp(1, 1'b1);
    done_delay = 0;
    req = 4'b0010;
    drain(60, n);
    chk("t4_cycles", 32'(n), 32'd21);

    // 5: reset during second beat of a 3-byte burst
    load(2, 2'd3, 8'h11, 8'h22, 8'h33);
    exp_beat(2, 8'h11); exp_beat(2, 8'h22);
    done_delay = 1;
    req = 4'b0100;
    step(); step();
    reset = 1'b0;
    step();
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_put", 32'({acc_put, data_ack}), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_value", 32'(acc_value), 32'd0);
    reset = 1'b1; req = '0;
    step();
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    load(1, 2'd1, 8'hB1, 8'h00, 8'h00);
    load(3, 2'd1, 8'hB3, 8'h00, 8'h00);
    exp_beat(1, 8'hB1); exp_rsp(1, 1'b0);
    exp_beat(3, 8'hB3); exp_rsp(3, 1'b0);
    req = 4'b1010;
    drain(60, n);

    // 6: len 0 behaves as 1; req[3] dropped mid-burst still completes
    do_reset();
    load(1, 2'd0, 8'h55, 8'hEE, 8'hEE);
    load(3, 2'd2, 8'h66, 8'h77, 8'h00);
    exp_beat(1, 8'h55); exp_rsp(1, 1'b0);
    exp_beat(3, 8'h66); exp_beat(3, 8'h77); exp_rsp(3, 1'b0);
    done_delay = 1;
    req = 4'b1010;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = gnt[3] & acc_put;
    end
    chk("t6_gnt3_seen", 32'(seen), 32'd1);
    req[3] = 1'b0;
    drain(40, n);

    step(); step();
    chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
